fetch_prefetch_unit: RTL

Parametrised instruction-fetch front end that succeeds the single-slot program counter. It keeps up to DEPTH fetched instructions in a circular queue, issues ibus requests ahead of decode, and handles redirects with in-flight response squashing. It injects misaligned-fetch and interrupt exception entries in program order. It sits between the ibus and the IF/ID boundary, feeding decode over a valid/ready handshake.

---
 rtl/fetch_prefetch_unit_pkg.sv | 53 +++++
 rtl/fetch_prefetch_unit_fetch_queue.sv | 56 +++++
 rtl/fetch_prefetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-path types: ibus request/response, exception causes and the
// entry format handed from the prefetch queue to decode.
package fetch_prefetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [4:0] {
        INSTRUCTION_ADDRESS_MISALIGNED = 5'd0,
        INSTRUCTION_ACCESS_FAULT       = 5'd1,
        ILLEGAL_INSTRUCTION            = 5'd2,
        BREAKPOINT                     = 5'd3,
        SUPERVISOR_SOFTWARE_INTERRUPT  = 5'd17,
        MACHINE_SOFTWARE_INTERRUPT     = 5'd19,
        SUPERVISOR_TIMER_INTERRUPT     = 5'd21,
        MACHINE_TIMER_INTERRUPT        = 5'd23,
        SUPERVISOR_EXTERNAL_INTERRUPT  = 5'd25,
        MACHINE_EXTERNAL_INTERRUPT     = 5'd27
    } exception_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [ILEN-1:0] instr;
        logic            exception_valid;
        exception_t      exception;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] pc,
                                                input logic [ILEN-1:0] instr,
                                                input logic            exc_valid,
                                                input exception_t      exc);
        fetch_entry_t e;
        e.pc              = pc;
        e.pc_plus4        = pc + 64'd4;
        e.instr           = instr;
        e.exception_valid = exc_valid;
        e.exception       = exc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fetch_queue.sv
// Circular buffer of fetch entries; head is visible combinationally so a
// completion lands at the queue output on the following cycle.
module fetch_queue
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq,
    input  fetch_entry_t                 enq_data,
    input  logic                         deq,
    output fetch_entry_t                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    logic           do_enq;
    logic           do_deq;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[head_reg];
    assign do_enq    = enq && !flush && !full;
    assign do_deq    = deq && !flush && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_enq) tail_reg <= tail_reg + PW'(1);
            if (do_deq) head_reg <= head_reg + PW'(1);
            case ({do_enq, do_deq})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[tail_reg] <= enq_data;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch front end: PC/request control, redirect squashing and
// in-order injection of misaligned-fetch and interrupt entries ahead of decode.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter logic [63:0] PCINIT = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output ibus_req_t    ibus_req,
    input  ibus_resp_t   ibus_resp,
    input  logic         redirect_en,
    input  logic [63:0]  redirect_addr,
    input  logic         hold,
    input  logic         int_pending,
    input  exception_t   int_cause,
    output logic         out_valid,
    input  logic         out_ready,
    output fetch_entry_t out_entry
);
    localparam int CW = $clog2(DEPTH+1);

    logic         req_valid_reg;
    logic [63:0]  req_addr_reg;
    logic [63:0]  fetch_pc_reg;
    logic         squash_reg;
    logic         halted_reg;

    fetch_entry_t q_head;
    fetch_entry_t q_enq_data;
    logic [CW-1:0] q_count;
    logic         q_full;
    logic         q_empty;
    logic [CW:0]  occupancy;

    logic complete, int_take, int_accept, flush, room, can_issue;
    logic issue, misalign, resp_enq, q_enq, q_deq;

    assign complete   = req_valid_reg && ibus_resp.addr_ok && ibus_resp.data_ok;
    assign int_take   = int_pending && !halted_reg;
    assign int_accept = int_take && out_ready && !redirect_en;
    assign flush      = redirect_en || int_accept;

    // The outstanding request already owns a slot, so it counts against capacity.
    assign occupancy  = {1'b0, q_count} + {{CW{1'b0}}, req_valid_reg};
    assign room       = !q_full && (occupancy < (CW+1)'(DEPTH));
    assign can_issue  = !req_valid_reg && !halted_reg && !hold && !flush && room;
    assign issue      = can_issue && (fetch_pc_reg[1:0] == 2'b00);
    assign misalign   = can_issue && (fetch_pc_reg[1:0] != 2'b00);

    assign resp_enq   = complete && !squash_reg;
    assign q_enq      = resp_enq || misalign;
    assign q_enq_data = misalign
                      ? make_entry(fetch_pc_reg, '0, 1'b1, INSTRUCTION_ADDRESS_MISALIGNED)
                      : make_entry(req_addr_reg, ibus_resp.data, 1'b0, INSTRUCTION_ADDRESS_MISALIGNED);
    assign q_deq      = !q_empty && out_ready && !int_take && !redirect_en;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq       (q_enq),
        .enq_data  (q_enq_data),
        .deq       (q_deq),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign ibus_req  = '{valid: req_valid_reg, addr: req_addr_reg};
    assign out_valid = int_take || !q_empty;

    // A pending interrupt masks the head so it is taken in program order.
    always_comb begin
        out_entry = '0;
        if (int_take)
            out_entry = make_entry(q_empty ? fetch_pc_reg : q_head.pc, '0, 1'b1, int_cause);
        else if (!q_empty)
            out_entry = q_head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_reg <= 1'b0;
            req_addr_reg  <= PCINIT;
            fetch_pc_reg  <= PCINIT;
            squash_reg    <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            if (complete) begin
                req_valid_reg <= 1'b0;
            end else if (issue) begin
                req_valid_reg <= 1'b1;
                req_addr_reg  <= fetch_pc_reg;
            end

            if (redirect_en)
                fetch_pc_reg <= redirect_addr;
            else if (issue)
                fetch_pc_reg <= fetch_pc_reg + 64'd4;

            if (flush)
                squash_reg <= req_valid_reg && !complete;
            else if (complete)
                squash_reg <= 1'b0;

            if (redirect_en)
                halted_reg <= 1'b0;
            else if (int_accept || misalign)
                halted_reg <= 1'b1;
        end
    end

endmodule
